// File: rtl/layer_seq_pkg.sv
// Shared types and default constants for the layer sequencer and its helpers.
package layer_seq_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    START   = 3'd1,
    COMPUTE = 3'd2,
    DRAIN   = 3'd3,
    DONE    = 3'd4,
    ERROR   = 3'd5
  } state_t;

  localparam int DEF_NUM_NEURONS    = 18;
  localparam int DEF_NUM_LAYERS     = 3;
  localparam int DEF_TIMEOUT_CYCLES = 4096;

  // Width of a layer index: at least one bit even for a single-layer network.
  function automatic int sel_width(input int n);
    return ($clog2(n) > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/layer_sequencer_if.sv
// Control/monitor bundle between the layer sequencer and the rest of the
// accelerator. The master side is the sequencer; mon_tvalid/mon_tready are
// observed copies of the connector stream and are never driven back.
// A beat counts only in a cycle where mon_tvalid and mon_tready are both high.
interface layer_sequencer_if #(
  parameter int NUM_NEURONS = layer_seq_pkg::DEF_NUM_NEURONS,
  parameter int LSW         = layer_seq_pkg::sel_width(layer_seq_pkg::DEF_NUM_LAYERS)
);
  import layer_seq_pkg::*;

  logic                   start;
  logic                   busy;
  logic                   neuron_start;
  logic [NUM_NEURONS-1:0] neuron_done;
  logic [LSW-1:0]         layer_sel;
  logic                   mon_tvalid;
  logic                   mon_tready;
  logic                   infer_done;
  logic                   error;
  logic [LSW-1:0]         err_layer;
  state_t                 dbg_state;

  modport master (
    input  start, neuron_done, mon_tvalid, mon_tready,
    output busy, neuron_start, layer_sel, infer_done, error, err_layer, dbg_state
  );

  modport slave (
    output start, neuron_done, mon_tvalid, mon_tready,
    input  busy, neuron_start, layer_sel, infer_done, error, err_layer, dbg_state
  );

endinterface

// File: rtl/layer_sequencer_watchdog.sv
// seq_watchdog: cycle counter that flags when it has spent TIMEOUT_CYCLES
// consecutive enabled cycles without being cleared. Clear wins over enable.
module seq_watchdog
  import layer_seq_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int TW = $clog2(TIMEOUT_CYCLES);

  logic [TW-1:0] tmo_cnt;

  // Count enabled cycles; clear restarts the window at zero.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tmo_cnt <= '0;
    end else if (clr) begin
      tmo_cnt <= '0;
    end else if (en) begin
      tmo_cnt <= tmo_cnt + TW'(1);
    end
  end

  // The last allowed cycle is the one where the count reads TIMEOUT_CYCLES-1.
  assign expired = en && (tmo_cnt == TW'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/layer_sequencer.sv
// layer_sequencer: steps an inference through NUM_LAYERS layers. Each layer
// gets one neuron_start pulse, waits until every neuron has reported done,
// then waits for NUM_NEURONS handshakes on the monitored output stream before
// moving to the next layer. A watchdog bounds COMPUTE and DRAIN.
// Optional build macro: LAYER_SEQ_PERF_CNT_EN adds the perf_cycles output.
module layer_sequencer
  import layer_seq_pkg::*;
#(
  parameter int NUM_NEURONS    = DEF_NUM_NEURONS,
  parameter int NUM_LAYERS     = DEF_NUM_LAYERS,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic                clk,
  input  logic                reset,
`ifdef LAYER_SEQ_PERF_CNT_EN
  output logic [31:0]         perf_cycles,
`endif
  layer_sequencer_if.master   bus
);

  localparam int LSW = sel_width(NUM_LAYERS);
  localparam int BW  = $clog2(NUM_NEURONS + 1);

  state_t                 state;
  logic                   busy_q;
  logic                   neuron_start_q;
  logic                   infer_done_q;
  logic [LSW-1:0]         layer_sel_q;
  logic                   error_q;
  logic [LSW-1:0]         err_layer_q;
  logic [NUM_NEURONS-1:0] done_mask;
  logic [BW-1:0]          beat_cnt;

  logic all_done;
  logic last_layer;
  logic beat_hs;
  logic drained;
  logic wd_clr;
  logic wd_en;
  logic wd_expired;

  // Exit conditions are evaluated on registered state only.
  assign all_done   = &done_mask;
  assign last_layer = (layer_sel_q == LSW'(NUM_LAYERS - 1));
  assign beat_hs    = bus.mon_tvalid & bus.mon_tready;
  assign drained    = (beat_cnt == BW'(NUM_NEURONS));

  // Watchdog runs only in COMPUTE/DRAIN and restarts on every entry to either.
  assign wd_en  = (state == COMPUTE) || (state == DRAIN);
  assign wd_clr = !wd_en || ((state == COMPUTE) && all_done);

  seq_watchdog #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk     (clk),
    .reset   (reset),
    .clr     (wd_clr),
    .en      (wd_en),
    .expired (wd_expired)
  );

  // Main sequencing FSM; every output is a register set on the transition.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state          <= IDLE;
      busy_q         <= 1'b0;
      neuron_start_q <= 1'b0;
      infer_done_q   <= 1'b0;
      layer_sel_q    <= '0;
      error_q        <= 1'b0;
      err_layer_q    <= '0;
      done_mask      <= '0;
      beat_cnt       <= '0;
    end else begin
      neuron_start_q <= 1'b0;
      infer_done_q   <= 1'b0;
      unique case (state)
        IDLE, ERROR: begin
          if (bus.start) begin
            state          <= START;
            busy_q         <= 1'b1;
            neuron_start_q <= 1'b1;
            layer_sel_q    <= '0;
            error_q        <= 1'b0;
          end
        end
        START: begin
          done_mask <= '0;
          state     <= COMPUTE;
        end
        COMPUTE: begin
          done_mask <= done_mask | bus.neuron_done;
          if (all_done) begin
            state    <= DRAIN;
            beat_cnt <= '0;
          end else if (wd_expired) begin
            state       <= ERROR;
            error_q     <= 1'b1;
            err_layer_q <= layer_sel_q;
          end
        end
        DRAIN: begin
          if (drained) begin
            if (last_layer) begin
              state        <= DONE;
              infer_done_q <= 1'b1;
            end else begin
              state          <= START;
              layer_sel_q    <= layer_sel_q + LSW'(1);
              neuron_start_q <= 1'b1;
            end
          end else if (wd_expired) begin
            state       <= ERROR;
            error_q     <= 1'b1;
            err_layer_q <= layer_sel_q;
          end else if (beat_hs) begin
            beat_cnt <= beat_cnt + BW'(1);
          end
        end
        DONE: begin
          state  <= IDLE;
          busy_q <= 1'b0;
        end
        default: begin
          state  <= IDLE;
          busy_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.busy         = busy_q;
  assign bus.neuron_start = neuron_start_q;
  assign bus.layer_sel    = layer_sel_q;
  assign bus.infer_done   = infer_done_q;
  assign bus.error        = error_q;
  assign bus.err_layer    = err_layer_q;
  assign bus.dbg_state    = state;

`ifdef LAYER_SEQ_PERF_CNT_EN
  logic [31:0] perf_q;
  logic        start_acc;

  assign start_acc = ((state == IDLE) || (state == ERROR)) && bus.start;

  // Busy-cycle counter: zeroed on an accepted start, saturating, frozen in IDLE.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      perf_q <= '0;
    end else if (start_acc) begin
      perf_q <= '0;
    end else if (busy_q && (perf_q != 32'hFFFF_FFFF)) begin
      perf_q <= perf_q + 32'd1;
    end
  end

  assign perf_cycles = perf_q;
`endif

endmodule
